// File: rtl/lc3b_types.sv
// lc3b_types -- shared LC-3b types for the memory access path.
//   lc3b_opcode     : 4-bit LC-3b opcode encoding
//   lc3b_ipacket    : decoded control packet handed to the MEM stage
//   lc3b_memstate_t : state encoding of the memory access FSM
package lc3b_types;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef struct packed {
      lc3b_opcode opcode;
      logic       mem_read;
      logic       mem_write;
      logic       byte_op;
   } lc3b_ipacket;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ1 = 2'd1,
      REQ2 = 2'd2,
      DONE = 2'd3
   } lc3b_memstate_t;

   // Only STR/STB write on the first access; STI's first access reads the pointer.
   function automatic logic first_access_is_write(input lc3b_opcode op);
      return (op == op_str) || (op == op_stb);
   endfunction

   function automatic logic is_indirect(input lc3b_opcode op);
      return (op == op_ldi) || (op == op_sti);
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit -- combinational byte-lane steering for the memory port.
//   i_byte_op     : access is a byte access (LDB/STB)
//   i_addr_lsb    : address bit 0, selects the byte lane
//   i_wdata       : store source data
//   i_rdata       : raw memory read data
//   o_byte_enable : lane enables (11 word, 01 low byte, 10 high byte)
//   o_wdata       : store data, low byte replicated on byte stores
//   o_load_data   : load result, selected byte sign-extended on byte loads
module byte_lane_unit (
   input  logic        i_byte_op,
   input  logic        i_addr_lsb,
   input  logic [15:0] i_wdata,
   input  logic [15:0] i_rdata,
   output logic [1:0]  o_byte_enable,
   output logic [15:0] o_wdata,
   output logic [15:0] o_load_data
);

   logic [7:0] w_lane;

   always_comb begin
      w_lane = i_addr_lsb ? i_rdata[15:8] : i_rdata[7:0];
      if (i_byte_op) begin
         o_byte_enable = i_addr_lsb ? 2'b10 : 2'b01;
         // Replicate so the byte lands correctly whichever lane is enabled.
         o_wdata       = {i_wdata[7:0], i_wdata[7:0]};
         o_load_data   = {{8{w_lane[7]}}, w_lane};
      end else begin
         o_byte_enable = 2'b11;
         o_wdata       = i_wdata;
         o_load_data   = i_rdata;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- MEM-stage controller for LC-3b loads/stores, including
// the two-access indirect forms LDI/STI.
//   clk, reset        : clock, synchronous active-high reset
//   valid_in, ipacket : decoded op presented this cycle
//   addr_in, wdata_in : effective address and store data
//   mem_*             : memory port (request, byte enables, response)
//   stall             : freeze upstream while an access is in flight
//   rdata_out         : most recent load result (held between loads)
//   done              : one-cycle completion strobe
//   misalign          : misaligned word access flagged together with done
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned word
// accesses (no request, straight to DONE with misalign). Without it, bit 0
// of word addresses is forced to 0 and misalign is tied low.
module mem_access_ctrl
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  lc3b_ipacket ipacket,
   input  logic [15:0] addr_in,
   input  logic [15:0] wdata_in,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_rdata,
   input  logic        mem_resp,
   output logic        stall,
   output logic [15:0] rdata_out,
   output logic        done,
   output logic        misalign
);

   lc3b_memstate_t r_state;
   lc3b_opcode     r_opcode;
   logic [15:0]    r_addr;
   logic [15:0]    r_wdata;
   logic           r_byte;
   logic           r_mem_read;
   logic           r_mem_write;
   logic           r_done;
   logic [15:0]    r_rdata;

   logic           w_mem_op;
   logic           w_in_store;
   logic           w_indirect;
   logic           w_in_misalign;
   logic           w_ptr_misalign;
   logic [1:0]     w_be;
   logic [15:0]    w_wdata;
   logic [15:0]    w_load_data;

   assign w_mem_op   = valid_in & (ipacket.mem_read | ipacket.mem_write);
   assign w_in_store = first_access_is_write(ipacket.opcode);
   assign w_indirect = is_indirect(r_opcode);

`ifdef MISALIGN_CHECK_EN
   assign w_in_misalign  = ~ipacket.byte_op & addr_in[0];
   // The indirect pointer is always a word address.
   assign w_ptr_misalign = mem_rdata[0];
`else
   assign w_in_misalign  = 1'b0;
   assign w_ptr_misalign = 1'b0;
`endif

   byte_lane_unit u_lanes (
      .i_byte_op     (r_byte),
      .i_addr_lsb    (r_addr[0]),
      .i_wdata       (r_wdata),
      .i_rdata       (mem_rdata),
      .o_byte_enable (w_be),
      .o_wdata       (w_wdata),
      .o_load_data   (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_opcode    <= op_br;
         r_addr      <= 16'h0000;
         r_wdata     <= 16'h0000;
         r_byte      <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_done      <= 1'b0;
         r_rdata     <= 16'h0000;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_mem_op) begin
                  r_addr   <= addr_in;
                  r_wdata  <= wdata_in;
                  r_opcode <= ipacket.opcode;
                  r_byte   <= ipacket.byte_op;
                  if (w_in_misalign) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= REQ1;
                     r_mem_read  <= ~w_in_store;
                     r_mem_write <= w_in_store;
                  end
               end
            end
            REQ1: begin
               if (mem_resp) begin
                  if (w_indirect) begin
                     // Reuse the address register for the pointer access.
                     r_addr <= mem_rdata;
                     r_byte <= 1'b0;
                     if (w_ptr_misalign) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                     end else begin
                        r_state     <= REQ2;
                        r_mem_read  <= (r_opcode == op_ldi);
                        r_mem_write <= (r_opcode == op_sti);
                     end
                  end else begin
                     r_state     <= DONE;
                     r_done      <= 1'b1;
                     r_mem_read  <= 1'b0;
                     r_mem_write <= 1'b0;
                     if (r_mem_read) r_rdata <= w_load_data;
                  end
               end
            end
            REQ2: begin
               if (mem_resp) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  if (r_opcode == op_ldi) r_rdata <= w_load_data;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef MISALIGN_CHECK_EN
   logic r_misalign;
   logic w_to_done_mis;

   // High exactly in the DONE cycle entered through a misaligned access.
   assign w_to_done_mis = ((r_state == IDLE) & w_mem_op & w_in_misalign) |
                          ((r_state == REQ1) & mem_resp & w_indirect & w_ptr_misalign);

   always_ff @(posedge clk) begin
      if (reset) r_misalign <= 1'b0;
      else       r_misalign <= w_to_done_mis;
   end

   assign misalign = r_misalign;
`else
   assign misalign = 1'b0;
`endif

   assign mem_address     = r_byte ? r_addr : {r_addr[15:1], 1'b0};
   assign mem_wdata       = w_wdata;
   assign mem_read        = r_mem_read;
   assign mem_write       = r_mem_write;
   assign mem_byte_enable = (r_mem_read | r_mem_write) ? w_be : 2'b00;
   assign stall           = (r_state == REQ1) | (r_state == REQ2) |
                            ((r_state == IDLE) & w_mem_op);
   assign rdata_out       = r_rdata;
   assign done            = r_done;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high.
REQ-002 SHALL have ports: valid_in in 1, ipacket presented this cycle; ipacket in lc3b_ipacket, decoded control (uses opcode, mem_read, mem_write, byte_op).
REQ-003 SHALL have ports: addr_in in 16, effective address from EXE; wdata_in in 16, store source data.
REQ-004 SHALL have ports: mem_address out 16; mem_wdata out 16; mem_read out 1; mem_write out 1; mem_byte_enable out 2; mem_rdata in 16; mem_resp in 1.
REQ-005 SHALL have ports: stall out 1, freeze upstream stages; rdata_out out 16, load result to WB; done out 1, one-cycle completion strobe; misalign out 1, error flag.

Function
REQ-006 SHALL implement FSM states IDLE, REQ1, REQ2, DONE.
REQ-007 IDLE: a memory op is valid_in & (ipacket.mem_read | ipacket.mem_write); on it, SHALL register address, data, opcode and byte_op, assert stall combinationally, and go to REQ1.
REQ-008 REQ1: SHALL drive the registered address; assert mem_read for loads, TRAP, LDI and STI; assert mem_write for STR and STB; hold until mem_resp.
REQ-009 REQ1 with mem_resp: for LDI/STI, SHALL latch mem_rdata as the pointer and go to REQ2; otherwise SHALL latch load data and go to DONE.
REQ-010 REQ2: SHALL access the pointer (read for LDI, write for STI), hold until mem_resp, then go to DONE.
REQ-011 DONE: SHALL pulse done=1 and stall=0 for one cycle, then return to IDLE; a memory op presented in DONE is not captured.
REQ-012 stall SHALL be 1 in REQ1 and REQ2, and in IDLE when a memory op is present; it is 0 otherwise.
REQ-013 mem_read and mem_write SHALL never be asserted together; both SHALL be 0 in IDLE and DONE.
REQ-014 Word access: mem_address[0] SHALL be 0 and mem_byte_enable=2'b11.
REQ-015 Byte access: mem_byte_enable SHALL be 2'b01 when addr[0]=0 and 2'b10 when addr[0]=1; STB mem_wdata SHALL be {wdata_in[7:0],wdata_in[7:0]}.
REQ-016 LDB: rdata_out SHALL be the selected byte, sign-extended to 16 bits; word loads SHALL pass mem_rdata unchanged.
REQ-017 rdata_out SHALL hold its value until the next load completes.
REQ-018 Latency: minimum 3 cycles (IDLE, REQ1 with same-cycle resp, DONE); indirect minimum 4 cycles.
REQ-019 mem_resp arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-020 On reset at a clock edge: state=IDLE; stall, done, misalign, mem_read, mem_write=0; mem_byte_enable=2'b00; rdata_out=16'h0000.
REQ-021 Reset during REQ1/REQ2 SHALL abandon the access with no completion strobe; requests drop from the next cycle.

Configuration
REQ-022 With MISALIGN_CHECK_EN defined: a word access (including the LDI/STI pointer) with address bit 0 set SHALL issue no memory request, go directly to DONE, and assert misalign together with done.
REQ-023 Without MISALIGN_CHECK_EN: address bit 0 SHALL be forced to 0 on word accesses, and misalign SHALL be tied to 0.

Structure
REQ-024 lc3b_types SHALL hold the FSM state enum lc3b_memstate_t; the op_ldi/op_sti/op_ldb/op_stb opcodes are reused from lc3b_types.
REQ-025 Byte-lane steering, store replication and LDB sign extension SHALL live in a combinational sub-module byte_lane_unit.

Verification
REQ-026 LDR addr 16'h3002, mem_rdata 16'hBEEF, resp after 2 cycles -> mem_read for 2 cycles at 16'h3002, be=11; DONE with rdata_out=16'hBEEF; stall drops in DONE.
REQ-027 LDB addr 16'h4001, mem_rdata 16'h8312 -> be=10, rdata_out=16'hFF83.
REQ-028 STB addr 16'h4000, wdata 16'h12A5 -> mem_wdata=16'hA5A5, be=01, mem_write=1, no mem_read.
REQ-029 LDI addr 16'h5000; first read returns 16'h6000; second read returns 16'h0042 -> second access at 16'h6000; rdata_out=16'h0042; done after 4+ cycles.
REQ-030 Reset asserted in REQ2 of STI -> next cycle IDLE, mem_write=0, no done; misaligned LDR at 16'h3003 -> with macro: no request, misalign=1 with done; without macro: read at 16'h3002.
